tft_spi_tx: RTL and testbench

Byte-level transmitter for the TFT display's 4-wire SPI interface. It consumes the `tft_transmit`/`tft_dc`/`tft_data` byte stream issued by the drawing blocks (player, maze, etc.) and serialises each byte MSB-first onto SCK/MOSI with the D/C line and chip select. It returns `tft_busy` so that upstream only issues a byte when `~tft_busy & ~tft_transmit`. It sits between the draw arbiter and the display pins.

---
 rtl/tft_pkg.sv | 15 +
 rtl/tft_sck_gen.sv | 41 ++++
 rtl/tft_spi_tx.sv | 126 ++++++++++++
 tb/tb_tft_spi_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared TFT definitions: transmitter state encoding and display command bytes.
package tft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } tx_state_e;

    // Display commands reused by every draw block
    localparam logic [7:0] CASET = 8'h2a;
    localparam logic [7:0] PASET = 8'h2b;
    localparam logic [7:0] RAMWR = 8'h2c;

endpackage

// File: rtl/tft_sck_gen.sv
// SCK divider: toggles SCK every CLK_DIV enabled cycles and flags rising/falling toggles.
module tft_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic sck,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned DW = $clog2(CLK_DIV + 1);

    logic [DW-1:0] div_q;
    logic          tick_c;

    assign tick_c = en && (div_q == DW'(CLK_DIV - 1));
    assign rise_c = tick_c && !sck;
    assign fall_c = tick_c && sck;

    // Divider and SCK level; restart re-phases both at the start of a byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            sck   <= 1'b0;
        end else if (restart) begin
            div_q <= '0;
            sck   <= 1'b0;
        end else if (en) begin
            if (tick_c) begin
                div_q <= '0;
                sck   <= !sck;
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

endmodule

// File: rtl/tft_spi_tx.sv
// Byte-level 4-wire SPI transmitter (mode 0, MSB first) for the TFT display.
module tft_spi_tx
    import tft_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tft_transmit,
    input  logic       tft_dc,
    input  logic [7:0] tft_data,
    output logic       tft_busy,
    output logic       tft_overrun,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_dc,
    output logic       spi_cs_n
);

    localparam int unsigned HW = (CS_HOLD > 0) ? $clog2(CS_HOLD + 1) : 1;

    tx_state_e     state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bit_q, bit_d;
    logic [HW-1:0] hold_q, hold_d, hold_nxt_c;
    logic          busy_d, overrun_d, mosi_d, dc_d, cs_n_d;
    logic          start_c, rise_c, fall_c;

    // A strobe is only honoured against the registered busy flag
    assign start_c    = tft_transmit && !tft_busy;
    assign hold_nxt_c = hold_q + HW'(1);

    tft_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (start_c),
        .en      (state_q == SHIFT),
        .sck     (spi_sck),
        .rise_c  (rise_c),
        .fall_c  (fall_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_q       <= '0;
            hold_q      <= '0;
            tft_busy    <= 1'b0;
            tft_overrun <= 1'b0;
            spi_mosi    <= 1'b0;
            spi_dc      <= 1'b0;
            spi_cs_n    <= 1'b1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_q       <= bit_d;
            hold_q      <= hold_d;
            tft_busy    <= busy_d;
            tft_overrun <= overrun_d;
            spi_mosi    <= mosi_d;
            spi_dc      <= dc_d;
            spi_cs_n    <= cs_n_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_d     = bit_q;
        hold_d    = hold_q;
        busy_d    = tft_busy;
        overrun_d = tft_overrun || (tft_transmit && tft_busy);
        mosi_d    = spi_mosi;
        dc_d      = spi_dc;
        cs_n_d    = spi_cs_n;

        case (state_q)
            IDLE, HOLD: begin
                if (start_c) begin
                    state_d = SHIFT;
                    shreg_d = tft_data;
                    dc_d    = tft_dc;
                    mosi_d  = tft_data[7];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                end else if (state_q == HOLD) begin
                    hold_d = hold_nxt_c;
                    if (hold_nxt_c == HW'(CS_HOLD)) begin
                        cs_n_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            SHIFT: begin
                // bit_q counts rising edges and wraps to 0 after the 8th
                if (rise_c) begin
                    bit_d = bit_q + 3'd1;
                end
                if (fall_c) begin
                    if (bit_q == 3'd0) begin
                        busy_d = 1'b0;
                        hold_d = '0;
                        if (CS_HOLD == 0) begin
                            state_d = IDLE;
                            cs_n_d  = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        mosi_d  = shreg_q[6];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tft_spi_tx.sv
// Bench for tft_spi_tx: directed scenarios plus a randomized draw stream, checked
// against a bit-capturing display model.
module tb_tft_spi_tx;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned CS_HOLD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx    = 1'b0;
    logic       dc    = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       busy, ovr, sck, mosi, sdc, cs_n;

    logic       tx_b   = 1'b0;
    logic       dc_b   = 1'b0;
    logic [7:0] data_b = 8'h00;
    logic       busy_b, ovr_b, sck_b, mosi_b, sdc_b, cs_n_b;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] cap_q[$];
    int         nbits = 0;
    logic [7:0] shin  = 8'h00;

    always #5 clk = ~clk;

    tft_spi_tx #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .tft_transmit(tx), .tft_dc(dc), .tft_data(data),
        .tft_busy(busy), .tft_overrun(ovr), .spi_sck(sck), .spi_mosi(mosi),
        .spi_dc(sdc), .spi_cs_n(cs_n)
    );

    tft_spi_tx #(.CLK_DIV(1), .CS_HOLD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tft_transmit(tx_b), .tft_dc(dc_b), .tft_data(data_b),
        .tft_busy(busy_b), .tft_overrun(ovr_b), .spi_sck(sck_b), .spi_mosi(mosi_b),
        .spi_dc(sdc_b), .spi_cs_n(cs_n_b)
    );

    // Display model: samples MOSI on SCK rise; releasing CS abandons a partial byte
    always @(posedge sck or posedge cs_n) begin
        if (cs_n) begin
            nbits = 0;
        end else begin
            shin  = {shin[6:0], mosi};
            nbits = nbits + 1;
            if (nbits == 8) begin
                cap_q.push_back({sdc, shin});
                nbits = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with busy high from the current cycle; also counts cs_n highs meanwhile
    task automatic wait_idle(output int n, output int hi);
        n  = 0;
        hi = 0;
        while (busy === 1'b1 && n < 2000) begin
            if (cs_n !== 1'b0) hi++;
            n++;
            tick();
        end
    endtask

    task automatic start(input logic d, input logic [7:0] b);
        chk("busy_before", 32'(busy), 0);
        tx   = 1'b1;
        dc   = d;
        data = b;
        exp_q.push_back({d, b});
        tick();
        tx = 1'b0;
        chk("busy_t1", 32'(busy), 1);
        chk("cs_t1", 32'(cs_n), 0);
        chk("mosi_t1", 32'(b[7]), 32'(mosi));
        chk("dc_t1", 32'(sdc), 32'(d));
    endtask

    task automatic finish();
        int n, hi;
        wait_idle(n, hi);
        chk("busy_len", 32'(n), 16 * CLK_DIV);
        chk("cs_low_in_byte", 32'(hi), 0);
        chk("sck_low_end", 32'(sck), 0);
    endtask

    // gap idle cycles after the previous byte; when after_byte, cs_n must reflect elapsed hold
    task automatic send(input logic d, input logic [7:0] b, input int gap, input bit after_byte);
        for (int i = 0; i < gap; i++) tick();
        if (after_byte) chk("cs_at_strobe", 32'(cs_n), 32'(gap >= int'(CS_HOLD)));
        start(d, b);
        finish();
    endtask

    task automatic hold_check();
        int k;
        k = 0;
        while (cs_n === 1'b0 && k < 100) begin
            tick();
            k++;
        end
        chk("cs_hold", 32'(k), CS_HOLD);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            chk(tag, 32'(cap_q[i]), 32'(exp_q[i]));
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n, hi;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(ovr), 0);
        chk("rst_sck", 32'(sck), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_dc", 32'(sdc), 0);
        chk("rst_cs_n", 32'(cs_n), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // CLK_DIV=1, CS_HOLD=0: cs_n releases on the same cycle busy falls
        chk("b_busy_before", 32'(busy_b), 0);
        tx_b = 1'b1; dc_b = 1'b1; data_b = 8'hff;
        tick();
        tx_b = 1'b0;
        chk("b_busy_t1", 32'(busy_b), 1);
        chk("b_mosi_t1", 32'(mosi_b), 1);
        chk("b_dc_t1", 32'(sdc_b), 1);
        n = 0;
        while (busy_b === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        chk("b_busy_len", 32'(n), 16);
        chk("b_cs_at_fall", 32'(cs_n_b), 1);
        chk("b_sck_end", 32'(sck_b), 0);
        chk("b_overrun", 32'(ovr_b), 0);

        // Command byte CASET
        send(1'b0, tft_pkg::CASET, 2, 1'b0);
        hold_check();
        check_stream("caset");

        // Back-to-back data bytes keep CS low throughout
        send(1'b1, 8'hA5, 3, 1'b0);
        send(1'b1, 8'h3C, 0, 1'b1);
        hold_check();
        check_stream("b2b");

        // Single byte: CS released exactly CS_HOLD cycles after busy falls
        send(1'b1, 8'hff, 2, 1'b0);
        hold_check();
        check_stream("ff");

        // Strobe while busy: byte in flight intact, overrun sticky
        start(1'b1, 8'hc3);
        for (int i = 0; i < 5; i++) tick();
        tx = 1'b1; dc = 1'b0; data = 8'h55;
        tick();
        tx = 1'b0;
        chk("overrun_set", 32'(ovr), 1);
        wait_idle(n, hi);
        chk("ovr_busy_len", 32'(n), 16 * CLK_DIV - 6);
        hold_check();
        check_stream("overrun");
        send(1'b1, 8'h81, 7, 1'b1);
        chk("overrun_sticky", 32'(ovr), 1);
        check_stream("after_ovr");

        // Asynchronous reset after the 3rd SCK rise
        hold_check();
        start(1'b0, 8'hf0);
        for (int i = 0; i < 5 * CLK_DIV; i++) tick();
        chk("sck_3rd_rise", 32'(sck), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sck", 32'(sck), 0);
        chk("arst_cs_n", 32'(cs_n), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_overrun", 32'(ovr), 0);
        void'(exp_q.pop_back());
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(1'b0, 8'h0f, 1, 1'b0);
        chk("post_rst_overrun", 32'(ovr), 0);
        hold_check();
        check_stream("post_rst");

        // Player draw sequence with random inter-byte gaps
        send(1'b0, tft_pkg::CASET, 1, 1'b0);
        for (int i = 0; i < 4; i++) send(1'b1, 8'($urandom), int'($urandom_range(0, 6)), 1'b1);
        send(1'b0, tft_pkg::PASET, int'($urandom_range(0, 6)), 1'b1);
        for (int i = 0; i < 4; i++) send(1'b1, 8'($urandom), int'($urandom_range(0, 6)), 1'b1);
        send(1'b0, tft_pkg::RAMWR, int'($urandom_range(0, 6)), 1'b1);
        for (int i = 0; i < 1452; i++) send(1'b1, 8'($urandom), int'($urandom_range(0, 6)), 1'b1);
        hold_check();
        check_stream("player");
        chk("player_overrun", 32'(ovr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
